mem_port_arbiter: RTL

//  Shares one single-port, 1-cycle-read-latency unified memory between the CPU instruction port (M0,

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/arb_prio_sel.sv | 38 +++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the memory macro.
// master = requesters plus memory response side, slave = the arbiter itself.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  localparam int BE_W = DATA_W / 8;

  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic [BE_W-1:0]   m1_we;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              s_en;
  logic [ADDR_W-1:0] s_addr;
  logic [BE_W-1:0]   s_we;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;

  modport master (
    output m0_req, m0_addr, m1_req, m1_addr, m1_we, m1_wdata, s_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    input  s_en, s_addr, s_we, s_wdata
  );

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_addr, m1_we, m1_wdata, s_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    output s_en, s_addr, s_we, s_wdata
  );

endinterface

// File: rtl/arb_prio_sel.sv
// Pure winner selection between fetch (M0) and data (M1) requests.
// ARB_ROUND_ROBIN_EN selects strict alternation instead of fixed priority with a starvation cap.
module arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    m0_req,
  input  logic                    m1_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e                  last_q,
`else
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
`endif
  output owner_e                  win
);

`ifndef ARB_ROUND_ROBIN_EN
  localparam logic [STARVE_CNT_W-1:0] LIMIT_CNT = STARVE_CNT_W'(STARVE_LIMIT);
`endif

  // A lone requester always wins; only contention consults the history.
  always_comb begin
    win = OWN_NONE;
    if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
`else
      win = (starve_cnt == LIMIT_CNT) ? OWN_M0 : OWN_M1;
`endif
    end else if (m0_req) begin
      win = OWN_M0;
    end else if (m1_req) begin
      win = OWN_M1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1-cycle-latency single-port memory between CPU fetch (M0) and data (M1) ports.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternating arbitration instead of fixed priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  owner_e            win;
  owner_e            owner_q;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_we;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q;
`else
  localparam logic [STARVE_CNT_W-1:0] LIMIT_CNT = STARVE_CNT_W'(STARVE_LIMIT);
  logic [STARVE_CNT_W-1:0] starve_cnt;
`endif

  arb_prio_sel #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .m0_req     (bus.m0_req),
    .m1_req     (bus.m1_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_q     (last_q),
`else
    .starve_cnt (starve_cnt),
`endif
    .win        (win)
  );

  assign bus.m0_gnt = (win == OWN_M0);
  assign bus.m1_gnt = (win == OWN_M1);

  // Reset only silences the memory enable; grants keep following the requests.
  assign bus.s_en   = (win != OWN_NONE) && !reset;

  // Idle and fetch cycles drive zero write lanes so the macro never sees a stray store.
  always_comb begin
    sel_addr  = '0;
    sel_we    = '0;
    sel_wdata = '0;
    case (win)
      OWN_M0: sel_addr = bus.m0_addr;
      OWN_M1: begin
        sel_addr  = bus.m1_addr;
        sel_we    = bus.m1_we;
        sel_wdata = bus.m1_wdata;
      end
      default: ;
    endcase
  end

  assign bus.s_addr  = sel_addr;
  assign bus.s_we    = sel_we;
  assign bus.s_wdata = sel_wdata;

  // Remember who owns the access now in flight so its response is steered back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= win;
    end
  end

  assign bus.m0_rvalid = (owner_q == OWN_M0);
  assign bus.m1_rvalid = (owner_q == OWN_M1);
  assign bus.m0_rdata  = bus.s_rdata;
  assign bus.m1_rdata  = bus.s_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  // Start as if M1 went last so the first contended grant goes to the fetch port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= OWN_M1;
    end else if (win != OWN_NONE) begin
      last_q <= win;
    end
  end
`else
  // Counts data grants that overtook a waiting fetch; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!bus.m0_req || (win == OWN_M0)) begin
      starve_cnt <= '0;
    end else if ((win == OWN_M1) && (starve_cnt != LIMIT_CNT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

endmodule
